// File: rtl/serial_tc_pkg.sv
// Shared types and decode helpers for the multi-channel bit-serial two's complementer.
package serial_tc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_CNEG = 2'b10
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The unused encoding 2'b11 folds into PASS so it can never negate.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_NEG;
      2'b10:   return MODE_CNEG;
      default: return MODE_PASS;
    endcase
  endfunction

  function automatic logic is_neg(input mode_t m, input logic sgn);
    return (m == MODE_NEG) || ((m == MODE_CNEG) && sgn);
  endfunction

endpackage

// File: rtl/serial_twos_comp_mc_if.sv
// Serial stream bundle: beat qualifiers, word controls, lane data and processed outputs.
interface serial_twos_comp_mc_if #(
  parameter int CHANNELS = 4
);
  logic                in_valid;
  logic                start;
  logic [1:0]          mode;
  logic                sign_in;
  logic [CHANNELS-1:0] i;
  logic [CHANNELS-1:0] y;
  logic                out_valid;
  logic                word_done;
  logic                busy;
  logic [CHANNELS-1:0] ovf;

  modport master (
    output in_valid, start, mode, sign_in, i,
    input  y, out_valid, word_done, busy, ovf
  );

  modport slave (
    input  in_valid, start, mode, sign_in, i,
    output y, out_valid, word_done, busy, ovf
  );
endinterface

// File: rtl/serial_tc_lane.sv
// One serial lane: invert every bit after the first 1 when negating, and flag the 100..0 word.
module serial_tc_lane (
  input  logic t_clk,
  input  logic r,
  input  logic beat,
  input  logic first,
  input  logic last,
  input  logic neg,
  input  logic i,
  output logic y,
  output logic ovf
);
  logic y_q, y_d;
  logic seen_one_q, seen_one_d;
  logic ovf_q, ovf_d;
  logic seen_eff;

  always_comb begin
    // Bit 0 of a word must not see the previous word's flag.
    seen_eff   = first ? 1'b0 : seen_one_q;
    y_d        = y_q;
    seen_one_d = seen_one_q;
    ovf_d      = ovf_q;
    if (beat) begin
      y_d        = (neg && seen_eff) ? ~i : i;
      seen_one_d = seen_eff | i;
      if (last) begin
        ovf_d = neg & ~seen_eff & i;
      end
    end
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      y_q        <= 1'b0;
      seen_one_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      y_q        <= y_d;
      seen_one_q <= seen_one_d;
      ovf_q      <= ovf_d;
    end
  end

  assign y   = y_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/serial_twos_comp_mc.sv
// Word-framed, multi-lane, LSB-first serial two's complementer with PASS/NEG/CNEG modes.
module serial_twos_comp_mc
  import serial_tc_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input logic                   t_clk,
  input logic                   r,
  serial_twos_comp_mc_if.slave  bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mode_t         mode_q, mode_d;
  logic          sign_q, sign_d;
  logic          out_valid_q, out_valid_d;
  logic          word_done_q, word_done_d;

  logic beat, first, last, neg;
  logic [CHANNELS-1:0] y_w, ovf_w;

  always_comb begin
    first = (state_q == ST_IDLE);
    beat  = bus.in_valid & (~first | bus.start);
    last  = ~first & (cnt_q == LAST_CNT);
    // The start beat is processed before the latches load, so decode it directly.
    neg   = first ? is_neg(decode_mode(bus.mode), bus.sign_in) : is_neg(mode_q, sign_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    sign_d      = sign_q;
    out_valid_d = beat;
    word_done_d = beat & last;

    if (beat) begin
      if (first) begin
        state_d = ST_RUN;
        cnt_d   = CW'(1);
        mode_d  = decode_mode(bus.mode);
        sign_d  = bus.sign_in;
      end else if (last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mode_q      <= MODE_PASS;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      word_done_q <= word_done_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
    serial_tc_lane u_lane (
      .t_clk (t_clk),
      .r     (r),
      .beat  (beat),
      .first (first),
      .last  (last),
      .neg   (neg),
      .i     (bus.i[gi]),
      .y     (y_w[gi]),
      .ovf   (ovf_w[gi])
    );
  end

  assign bus.y         = y_w;
  assign bus.ovf       = ovf_w;
  assign bus.out_valid = out_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = (state_q == ST_RUN);
endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Randomised scoreboard bench: whole-word arithmetic model feeds a per-bit expectation queue.
module tb_serial_twos_comp_mc;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef logic [CH-1:0][W-1:0] word_t;
  typedef struct packed {
    logic [CH-1:0] y;
    logic          wd;
    logic [CH-1:0] ovf;
  } exp_t;

  logic t_clk = 1'b0;
  logic r     = 1'b0;

  serial_twos_comp_mc_if #(.CHANNELS(CH)) bus ();

  serial_twos_comp_mc #(.CHANNELS(CH), .WIDTH(W)) dut (
    .t_clk (t_clk),
    .r     (r),
    .bus   (bus)
  );

  always #5 t_clk = ~t_clk;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [CH-1:0] ovf_model;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            word_no  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic drive(input logic v, input logic st, input logic [1:0] md,
                       input logic sg, input logic [CH-1:0] iv);
    bus.in_valid = v;
    bus.start    = st;
    bus.mode     = md;
    bus.sign_in  = sg;
    bus.i        = iv;
    @(posedge t_clk);
    #1;
  endtask

  // Expected word = arithmetic negation (mod 2^W) when negating; ovf only for the 100..0 word.
  task automatic send_word(input logic [1:0] md, input logic sgn, input word_t data,
                           input int gap_mask, input int gap_len,
                           input int stray_bit, input int abort_after);
    logic          neg;
    word_t         res;
    logic [CH-1:0] ovf_new, iv, yv;
    exp_t          e;
    neg = (md == 2'b01) || ((md == 2'b10) && sgn);
    for (int k = 0; k < CH; k++) begin
      res[k]     = neg ? (~data[k] + 1'b1) : data[k];
      ovf_new[k] = neg && (data[k] == MOST_NEG);
    end
    $display("word %0d mode=%0d sign=%0d data=%h expect=%h ovf=%b", word_no, md, sgn, data, res, ovf_new);
    word_no++;
    for (int b = 0; b < W; b++) begin
      for (int k = 0; k < CH; k++) begin
        iv[k] = data[k][b];
        yv[k] = res[k][b];
      end
      e.y   = yv;
      e.wd  = (b == W - 1);
      e.ovf = (b == W - 1) ? ovf_new : ovf_model;
      if (b == W - 1) ovf_model = ovf_new;
      exp_q.push_back(e);
      if (b == 0) begin
        drive(1'b1, 1'b1, md, sgn, iv);
        check("busy_after_start", bus.busy, 1);
      end else if (b == stray_bit) begin
        drive(1'b1, 1'b1, 2'($urandom), 1'($urandom), iv);
      end else begin
        drive(1'b1, 1'b0, md, sgn, iv);
      end
      if (b == abort_after) return;
      if (gap_mask[b]) begin
        repeat (gap_len) drive(1'b0, 1'($urandom), 2'($urandom), 1'($urandom), CH'($urandom));
      end
    end
  endtask

  task automatic idle_beats(input int n);
    repeat (n) drive(1'b1, 1'b0, 2'($urandom), 1'($urandom), CH'($urandom));
  endtask

  initial begin
    forever begin
      @(negedge t_clk);
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("y", bus.y, mon_e.y);
          check("word_done", bus.word_done, mon_e.wd);
          check("ovf", bus.ovf, mon_e.ovf);
        end
      end else begin
        check("word_done_without_valid", bus.word_done, 0);
      end
    end
  end

  initial begin
    word_t d;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 2'b00;
    bus.sign_in  = 1'b0;
    bus.i        = '0;
    ovf_model    = '0;
    r            = 1'b1;
    #12;
    check("reset_y", bus.y, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_word_done", bus.word_done, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ovf", bus.ovf, 0);
    r = 1'b0;
    @(posedge t_clk);
    #1;

    send_word(2'b01, 1'b0, {8'h7F, 8'h00, 8'h01, 8'h06}, 0, 0, -1, -1);
    send_word(2'b01, 1'b0, {8'h05, 8'h05, 8'h05, 8'h80}, 0, 0, -1, -1);
    send_word(2'b00, 1'b0, {4{8'h11}}, 0, 0, -1, -1);
    send_word(2'b10, 1'b0, {4{8'h2C}}, 0, 0, -1, -1);
    send_word(2'b10, 1'b1, {4{8'h2C}}, 0, 0, -1, -1);
    send_word(2'b01, 1'b0, {4{8'h0A}}, 32'h22, 3, -1, -1);
    send_word(2'b01, 1'b0, {8'h3C, 8'hA5, 8'h80, 8'h01}, 0, 0, 3, -1);
    idle_beats(3);
    check("no_busy_idle_beats", bus.busy, 0);

    // Abort a NEG word after bit 4 while ovf from the previous word is still set.
    send_word(2'b01, 1'b0, {4{8'h80}}, 0, 0, -1, -1);
    send_word(2'b01, 1'b0, {4{8'h5A}}, 0, 0, -1, 4);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    @(negedge t_clk);
    #1;
    r = 1'b1;
    #1;
    check("midreset_y", bus.y, 0);
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_word_done", bus.word_done, 0);
    check("midreset_busy", bus.busy, 0);
    check("midreset_ovf", bus.ovf, 0);
    exp_q.delete();
    ovf_model = '0;
    #1;
    r = 1'b0;
    @(posedge t_clk);
    #1;
    send_word(2'b01, 1'b0, {4{8'h03}}, 0, 0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < CH; k++) begin
        case ($urandom_range(0, 7))
          0, 1:    d[k] = MOST_NEG;
          2:       d[k] = '0;
          default: d[k] = W'($urandom);
        endcase
      end
      send_word(2'($urandom), 1'($urandom), d,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0,
                int'($urandom_range(1, 3)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1,
                -1);
      if ($urandom_range(0, 2) == 0) idle_beats(int'($urandom_range(1, 3)));
    end

    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge t_clk);
    check("drain_queue", exp_q.size(), 0);
    repeat (2) @(posedge t_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_twos_comp_mc.md
Name: serial_twos_comp_mc

Overview:
Multi-channel, word-framed, bit-serial two's complementer. It processes CHANNELS independent LSB-first serial streams in lock-step. Each word is WIDTH bits long and carries a per-word mode: pass, negate, or conditional negate. The block sits between serial data sources and downstream serial consumers. It is the parametrised successor of the single-bit, free-running complementer: it adds word framing, a valid handshake, multiple modes and overflow detection.

Parameters:
CHANNELS, 4, number of parallel serial lanes (>=1)
WIDTH, 8, bits per word (>=2); bit counter width is $clog2(WIDTH)

Ports:
t_clk  in  1  clock, rising edge
r  in  1  reset, asynchronous, active-high
in_valid  in  1  beat qualifier; one bit per lane is accepted when high
start  in  1  marks the first beat (bit 0) of a word; sampled only with in_valid
mode  in  2  word mode, sampled with start: 00 PASS, 01 NEG, 10 CNEG, 11 treated as PASS
sign_in  in  1  sampled with start; in CNEG, 1 = negate this word, 0 = pass it
i  in  CHANNELS  serial input bits, LSB first, one per lane
y  out  CHANNELS  serial output bits, registered
out_valid  out  1  y holds a processed bit
word_done  out  1  pulses with out_valid on the output of bit WIDTH-1
busy  out  1  high while in RUN
ovf  out  CHANNELS  per-lane overflow from negating the most negative value; held until the next word_done

Behaviour:
- Reset (async, r=1): all outputs go to 0, state goes to IDLE, bit counter is 0, per-lane seen_one flags are 0 and the latched mode is PASS.
- Accepted beat: any cycle with in_valid=1 that is either in RUN, or in IDLE with start=1. in_valid=0 stalls everything; out_valid=0 the next cycle and y holds its last value.
- FSM IDLE:
  - Beat with start=1: latch mode and sign_in, process the beat as bit 0, counter goes to 1, go to RUN.
  - in_valid without start is ignored.
- FSM RUN:
  - Each accepted beat increments the counter.
  - On the beat where counter==WIDTH-1: next-cycle word_done=1 and the counter goes to 0.
  - If start=1 on that same beat: ignored. This beat is the last bit, not a new word.
  - Exit from RUN: go to IDLE. Back-to-back words are allowed: a start beat on the very next cycle is accepted in IDLE with no bubble.
  - start on a beat that is not the last bit is ignored. It is not an error.
- Effective negate: neg = (mode==NEG) | (mode==CNEG & sign_latched).
- Per-lane datapath for each accepted beat:
  - Output bit: y_next = neg & seen_one ? ~i : i.
  - Flag update: seen_one |= i.
  - seen_one is cleared at the start of every word. Bit 0 uses seen_one=0.
- Latency: exactly 1 cycle from accepted beat to out_valid/y.
- Overflow: on the last beat, lane k sets ovf[k] = neg & ~seen_one[k] & i[k]. This is the 100..0 input, whose output equals the input. ovf updates only with word_done; otherwise it holds.
- A zero word under negate outputs zero with ovf=0.
- PASS: y = i delayed by 1 cycle and ovf=0.
- Reset mid-word: the word is abandoned and there is no word_done. The first accepted start after reset begins a fresh word.

Decomposition:
- Package serial_tc_pkg holds:
  - mode_t enum (MODE_PASS=2'b00, MODE_NEG=2'b01, MODE_CNEG=2'b10)
  - state_t (ST_IDLE, ST_RUN)
- Sub-module serial_tc_lane, instantiated CHANNELS times via generate. It owns:
  - the seen_one flag
  - the registered y bit
  - the ovf bit
  - inputs: t_clk, r, beat, first, last, neg, i
- The top level owns the FSM, bit counter, mode/sign latches, out_valid, word_done and busy.

Test Plan:
- NEG, CHANNELS=4, WIDTH=8, lanes = 0x06, 0x01, 0x00, 0x7F, continuous in_valid:
  - outputs 0xFA, 0xFF, 0x00, 0x81 LSB first
  - word_done on the 8th out_valid cycle
  - ovf=4'b0000
- NEG, lane0=0x80, others 0x05:
  - lane0 output 0x80 and ovf[0]=1; others 0xFB with ovf=0
  - ovf holds through a following PASS word until that word's word_done, then clears to 0
- CNEG back-to-back, sign_in=0 then sign_in=1, same data 0x2C:
  - word1 outputs 0x2C; word2 outputs 0xD4
  - no idle cycle between words; busy stays high except one cycle in IDLE handled by the start beat
- in_valid gaps: NEG 0x0A with in_valid low for 3 cycles after bits 1 and 5:
  - output 0xF6
  - out_valid low during gaps; word_done only after the 8th accepted beat
- Stray controls:
  - start mid-word (bit 3) is ignored and the word completes normally
  - in_valid without start in IDLE produces no out_valid
- Reset mid-word: assert r after bit 4 of a NEG word:
  - y, out_valid, word_done, busy and ovf go to 0 immediately
  - the next NEG 0x03 word outputs 0xFD correctly
